// File: rtl/timer_cnt_ctrl_if.sv
// Timer control/status bundle between the APB register file and the timer core.
// master: register-file side (drives TCR/TDR/TCMP fields and clear pulses).
// slave:  timer core side (returns count, sticky flags, running and irq).
interface timer_cnt_ctrl_if #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned SEL_W = 2
);
    logic             en;
    logic             load;
    logic             dw;
    logic [1:0]       mode;
    logic [SEL_W-1:0] clk_sel;
    logic [CNT_W-1:0] ld_val;
    logic [CNT_W-1:0] cmp_val;
    logic [2:0]       trig_clr;
    logic [2:0]       irq_en;
    logic [CNT_W-1:0] cnt;
    logic             ovf_trig;
    logic             udf_trig;
    logic             cmp_trig;
    logic             running;
    logic             irq;

    modport master (
        output en, load, dw, mode, clk_sel, ld_val, cmp_val, trig_clr, irq_en,
        input  cnt, ovf_trig, udf_trig, cmp_trig, running, irq
    );

    modport slave (
        input  en, load, dw, mode, clk_sel, ld_val, cmp_val, trig_clr, irq_en,
        output cnt, ovf_trig, udf_trig, cmp_trig, running, irq
    );
endinterface

// File: rtl/timer_cnt_ctrl.sv
// Timer core: prescaler, CNT_W-bit up/down counter with wrap / auto-reload / one-shot
// modes, sticky set-wins event flags and a maskable combinational interrupt.
// Optional compare-match flag is built only when TIMER_CMP_EN is defined.
module timer_cnt_ctrl #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned SEL_W = 2
) (
    input logic             pclk,
    input logic             preset,
    timer_cnt_ctrl_if.slave bus
);
    localparam int unsigned      DIV_W       = 1 << SEL_W;
    localparam logic [CNT_W-1:0] CntOne      = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntMax      = '1;
    localparam logic [DIV_W-1:0] DivOne      = DIV_W'(1);
    localparam logic [1:0]       ModeReload  = 2'b01;
    localparam logic [1:0]       ModeOneShot = 2'b10;

    // StSpent: a one-shot event has fired and counting is parked until en drops.
    typedef enum logic [0:0] {StArmed, StSpent} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_step;
    logic [DIV_W-1:0] div_q, div_d, div_mask;
    logic             ovf_q, ovf_d, udf_q, udf_d;
    logic             cmp_flag;
    logic             armed, running, tick;
    logic             ovf_set, udf_set, evt, evt_reload;

    // State register: counter, prescaler, sticky flags and arm state.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q <= StArmed;
            cnt_q   <= '0;
            div_q   <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Arm-state next-state: one-shot event disarms, any edge with en low re-arms.
    always_comb begin
        state_d = state_q;
        if (!bus.en) begin
            state_d = StArmed;
        end else if (evt && (bus.mode == ModeOneShot)) begin
            state_d = StSpent;
        end
    end

    // Arm-state outputs; reset gates running so it drops without waiting for an edge.
    always_comb begin
        armed   = (state_q == StArmed);
        running = bus.en & armed & ~bus.load & ~preset;
    end

    // Datapath next-state: prescaler tick, count step, events and flag set/clear.
    always_comb begin
        // Low clk_sel+1 bits of div_q all ones -> divide by 2^(clk_sel+1).
        div_mask = '0;
        for (int i = 0; i < int'(DIV_W); i++) begin
            div_mask[i] = (i <= int'(bus.clk_sel));
        end
        tick       = running & ((div_q & div_mask) == div_mask);
        cnt_step   = bus.dw ? (cnt_q - CntOne) : (cnt_q + CntOne);
        ovf_set    = tick & ~bus.dw & (cnt_q == CntMax);
        udf_set    = tick & bus.dw & (cnt_q == '0);
        evt        = ovf_set | udf_set;
        evt_reload = evt & ((bus.mode == ModeReload) | (bus.mode == ModeOneShot));

        cnt_d = cnt_q;
        if (bus.load) begin
            cnt_d = bus.ld_val;
        end else if (tick) begin
            cnt_d = evt_reload ? bus.ld_val : cnt_step;
        end

        div_d = running ? (div_q + DivOne) : '0;
        // Set wins over a same-edge clear so no event is lost.
        ovf_d = ovf_set | (ovf_q & ~bus.trig_clr[0]);
        udf_d = udf_set | (udf_q & ~bus.trig_clr[1]);
    end

`ifdef TIMER_CMP_EN
    logic cmp_q, cmp_d;

    // Compare flag register.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            cmp_q <= 1'b0;
        end else begin
            cmp_q <= cmp_d;
        end
    end

    // Compare-match sets only on tick edges (reloads included), never on load.
    always_comb begin
        cmp_d = (tick & (cnt_d == bus.cmp_val)) | (cmp_q & ~bus.trig_clr[2]);
    end

    assign cmp_flag = cmp_q;
`else
    logic unused_cmp;

    assign cmp_flag   = 1'b0;
    assign unused_cmp = ^{bus.cmp_val, bus.trig_clr[2]};
`endif

    // Status outputs and masked interrupt.
    always_comb begin
        bus.cnt      = cnt_q;
        bus.ovf_trig = ovf_q;
        bus.udf_trig = udf_q;
        bus.cmp_trig = cmp_flag;
        bus.running  = running;
        bus.irq      = |({cmp_flag, udf_q, ovf_q} & bus.irq_en);
    end
endmodule

// File: tb/tb_timer_cnt_ctrl.sv
// Self-checking bench for timer_cnt_ctrl: directed scenarios plus randomized stimulus,
// every cycle compared against a behavioural model of the timer.
module tb_timer_cnt_ctrl;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned SEL_W  = 2;
    localparam int          CntMod = 1 << CNT_W;
    localparam int          DivMod = 1 << (1 << SEL_W);
`ifdef TIMER_CMP_EN
    localparam bit CmpEn = 1'b1;
`else
    localparam bit CmpEn = 1'b0;
`endif

    logic pclk = 1'b0;
    logic preset = 1'b1;

    timer_cnt_ctrl_if #(.CNT_W(CNT_W), .SEL_W(SEL_W)) bus ();

    timer_cnt_ctrl #(.CNT_W(CNT_W), .SEL_W(SEL_W)) dut (
        .pclk   (pclk),
        .preset (preset),
        .bus    (bus)
    );

    always #5 pclk = ~pclk;

    int n_tests;
    int n_fail;

    // Model state.
    int m_cnt;
    int m_run_cycles;
    bit m_ovf, m_udf, m_cmp, m_armed;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt        = 0;
        m_run_cycles = 0;
        m_ovf        = 1'b0;
        m_udf        = 1'b0;
        m_cmp        = 1'b0;
        m_armed      = 1'b1;
    endtask

    function automatic bit m_running();
        return bus.en && m_armed && !bus.load;
    endfunction

    function automatic bit m_irq();
        return (m_ovf && bus.irq_en[0]) || (m_udf && bus.irq_en[1]) || (m_cmp && bus.irq_en[2]);
    endfunction

    // One clock edge of the timer, from the behavioural rules.
    task automatic model_edge();
        bit run, tk, set_o, set_u, set_c, evt;
        int period, nxt;
        run    = m_running();
        period = 2 << bus.clk_sel;
        tk     = run && ((m_run_cycles % period) == period - 1);
        set_o  = 1'b0;
        set_u  = 1'b0;
        set_c  = 1'b0;
        evt    = 1'b0;
        nxt    = m_cnt;
        if (bus.load) begin
            nxt = int'(bus.ld_val);
        end else if (tk) begin
            if (!bus.dw) begin
                set_o = (m_cnt == CntMod - 1);
                nxt   = (m_cnt + 1) % CntMod;
            end else begin
                set_u = (m_cnt == 0);
                nxt   = (m_cnt + CntMod - 1) % CntMod;
            end
            evt = set_o || set_u;
            if (evt && (bus.mode == 2'd1 || bus.mode == 2'd2)) nxt = int'(bus.ld_val);
            set_c = CmpEn && (nxt == int'(bus.cmp_val));
        end
        m_run_cycles = run ? (m_run_cycles + 1) % DivMod : 0;
        if (!bus.en) m_armed = 1'b1;
        else if (evt && bus.mode == 2'd2) m_armed = 1'b0;
        m_ovf = set_o || (m_ovf && !bus.trig_clr[0]);
        m_udf = set_u || (m_udf && !bus.trig_clr[1]);
        m_cmp = set_c || (m_cmp && !bus.trig_clr[2]);
        m_cnt = nxt;
    endtask

    task automatic compare_all(input string ph);
        check_eq({ph, ":cnt"}, 32'(bus.cnt), 32'(m_cnt));
        check_eq({ph, ":ovf"}, 32'(bus.ovf_trig), 32'(m_ovf));
        check_eq({ph, ":udf"}, 32'(bus.udf_trig), 32'(m_udf));
        check_eq({ph, ":cmp"}, 32'(bus.cmp_trig), 32'(m_cmp));
        check_eq({ph, ":running"}, 32'(bus.running), 32'(m_running()));
        check_eq({ph, ":irq"}, 32'(bus.irq), 32'(m_irq()));
    endtask

    // Called at a falling edge with inputs already driven.
    task automatic step(input string ph);
        #1;
        compare_all(ph);
        @(posedge pclk);
        model_edge();
        @(negedge pclk);
    endtask

    task automatic steps(input string ph, input int n);
        for (int k = 0; k < n; k++) step(ph);
    endtask

    task automatic randomize_inputs();
        bus.en   = ($urandom_range(0, 15) != 0);
        bus.load = ($urandom_range(0, 31) == 0);
        if ($urandom_range(0, 63) == 0) bus.dw = 1'($urandom);
        if ($urandom_range(0, 63) == 0) bus.mode = 2'($urandom);
        if ($urandom_range(0, 63) == 0) bus.clk_sel = SEL_W'($urandom_range(0, 3));
        if ($urandom_range(0, 15) == 0) begin
            case ($urandom_range(0, 4))
                0:       bus.ld_val = CNT_W'(0);
                1:       bus.ld_val = CNT_W'(1);
                2:       bus.ld_val = CNT_W'(CntMod - 2);
                3:       bus.ld_val = CNT_W'(CntMod - 1);
                default: bus.ld_val = CNT_W'($urandom);
            endcase
        end
        if ($urandom_range(0, 31) == 0) bus.cmp_val = CNT_W'($urandom);
        if ($urandom_range(0, 31) == 0) bus.irq_en = 3'($urandom);
        bus.trig_clr[0] = ($urandom_range(0, 7) == 0);
        bus.trig_clr[1] = ($urandom_range(0, 7) == 0);
        bus.trig_clr[2] = ($urandom_range(0, 7) == 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        bus.en      = 1'b1;
        bus.load    = 1'b0;
        bus.dw      = 1'b0;
        bus.mode    = 2'd0;
        bus.clk_sel = '0;
        bus.ld_val  = '0;
        bus.cmp_val = CNT_W'(8'h80);
        bus.trig_clr = 3'b000;
        bus.irq_en  = 3'b111;

        // Reset state, with en high to show running is held low.
        #3;
        model_reset();
        check_eq("rst_cnt", 32'(bus.cnt), 32'h0);
        check_eq("rst_ovf", 32'(bus.ovf_trig), 32'h0);
        check_eq("rst_udf", 32'(bus.udf_trig), 32'h0);
        check_eq("rst_cmp", 32'(bus.cmp_trig), 32'h0);
        check_eq("rst_running", 32'(bus.running), 32'h0);
        check_eq("rst_irq", 32'(bus.irq), 32'h0);
        @(negedge pclk);
        bus.en = 1'b0;
        preset = 1'b0;

        // Up count through overflow in wrap mode, divide by 2.
        bus.load   = 1'b1;
        bus.ld_val = CNT_W'(8'hFD);
        bus.irq_en = 3'b000;
        step("s1");
        bus.load = 1'b0;
        bus.en   = 1'b1;
        steps("s1", 2);
        check_eq("s1_fe", 32'(bus.cnt), 32'hFE);
        steps("s1", 2);
        check_eq("s1_ff", 32'(bus.cnt), 32'hFF);
        steps("s1", 2);
        check_eq("s1_wrap", 32'(bus.cnt), 32'h00);
        check_eq("s1_ovf", 32'(bus.ovf_trig), 32'h1);
        check_eq("s1_udf", 32'(bus.udf_trig), 32'h0);

        // Clear alone, then clear colliding with a new overflow.
        bus.trig_clr = 3'b001;
        step("s4");
        check_eq("s4_clr_alone", 32'(bus.ovf_trig), 32'h0);
        bus.trig_clr = 3'b000;
        bus.load     = 1'b1;
        bus.ld_val   = CNT_W'(8'hFF);
        step("s4");
        bus.load = 1'b0;
        step("s4");
        bus.trig_clr = 3'b001;
        step("s4");
        check_eq("s4_set_wins", 32'(bus.ovf_trig), 32'h1);
        bus.trig_clr = 3'b000;

        // Down count with auto-reload, divide by 4.
        bus.dw      = 1'b1;
        bus.mode    = 2'd1;
        bus.clk_sel = SEL_W'(1);
        bus.ld_val  = CNT_W'(8'h03);
        bus.load    = 1'b1;
        step("s2");
        bus.load = 1'b0;
        steps("s2", 4);
        check_eq("s2_02", 32'(bus.cnt), 32'h02);
        steps("s2", 8);
        check_eq("s2_00", 32'(bus.cnt), 32'h00);
        check_eq("s2_no_udf", 32'(bus.udf_trig), 32'h0);
        steps("s2", 4);
        check_eq("s2_reload", 32'(bus.cnt), 32'h03);
        check_eq("s2_udf", 32'(bus.udf_trig), 32'h1);
        check_eq("s2_irq_masked", 32'(bus.irq), 32'h0);
        bus.irq_en = 3'b010;
        #1;
        check_eq("s2_irq_on", 32'(bus.irq), 32'h1);

        // One-shot: stops after the event, re-armed by dropping en.
        bus.irq_en  = 3'b000;
        bus.dw      = 1'b0;
        bus.mode    = 2'd2;
        bus.clk_sel = SEL_W'(0);
        bus.ld_val  = CNT_W'(8'hFE);
        bus.load    = 1'b1;
        step("s3");
        bus.load = 1'b0;
        steps("s3", 2);
        check_eq("s3_ff", 32'(bus.cnt), 32'hFF);
        steps("s3", 2);
        check_eq("s3_reload", 32'(bus.cnt), 32'hFE);
        check_eq("s3_stopped", 32'(bus.running), 32'h0);
        steps("s3", 4);
        check_eq("s3_hold", 32'(bus.cnt), 32'hFE);
        bus.en = 1'b0;
        step("s3");
        bus.en = 1'b1;
        steps("s3", 2);
        check_eq("s3_rearm", 32'(bus.cnt), 32'hFF);

`ifdef TIMER_CMP_EN
        // Compare match on counting, never on load.
        bus.mode     = 2'd0;
        bus.cmp_val  = CNT_W'(8'h05);
        bus.ld_val   = CNT_W'(8'h00);
        bus.load     = 1'b1;
        bus.trig_clr = 3'b100;
        step("s5");
        bus.load     = 1'b0;
        bus.trig_clr = 3'b000;
        steps("s5", 10);
        check_eq("s5_cnt", 32'(bus.cnt), 32'h05);
        check_eq("s5_cmp", 32'(bus.cmp_trig), 32'h1);
        bus.ld_val   = CNT_W'(8'h05);
        bus.load     = 1'b1;
        bus.trig_clr = 3'b100;
        step("s5");
        bus.trig_clr = 3'b000;
        step("s5");
        check_eq("s5_load_no_cmp", 32'(bus.cmp_trig), 32'h0);
        bus.load = 1'b0;
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            randomize_inputs();
            step("rnd");
        end

        // Asynchronous reset mid-count with flags set.
        bus.trig_clr = 3'b000;
        bus.en       = 1'b0;
        bus.dw       = 1'b0;
        bus.mode     = 2'd0;
        bus.clk_sel  = SEL_W'(0);
        bus.ld_val   = CNT_W'(8'hFF);
        bus.load     = 1'b1;
        step("s6");
        bus.load = 1'b0;
        bus.en   = 1'b1;
        steps("s6", 2);
        bus.ld_val = CNT_W'(8'h79);
        bus.load   = 1'b1;
        step("s6");
        bus.load = 1'b0;
        steps("s6", 2);
        check_eq("s6_pre_cnt", 32'(bus.cnt), 32'h7A);
        check_eq("s6_pre_ovf", 32'(bus.ovf_trig), 32'h1);
        bus.irq_en = 3'b111;
        #2;
        preset = 1'b1;
        #1;
        check_eq("s6_cnt", 32'(bus.cnt), 32'h0);
        check_eq("s6_ovf", 32'(bus.ovf_trig), 32'h0);
        check_eq("s6_udf", 32'(bus.udf_trig), 32'h0);
        check_eq("s6_running", 32'(bus.running), 32'h0);
        check_eq("s6_irq", 32'(bus.irq), 32'h0);
        model_reset();
        @(negedge pclk);
        bus.en = 1'b0;
        preset = 1'b0;
        step("post");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
